// File: rtl/spi_responder_pkg.sv
// rtl/spi_responder_pkg.sv - shared state encodings and constants for the SPI register responder
package spi_responder_pkg;
  typedef logic [2:0] state_t;

  localparam state_t ST_WAIT_CS = 3'd0;
  localparam state_t ST_IDLE    = 3'd1;
  localparam state_t ST_ADDR    = 3'd2;
  localparam state_t ST_DATA    = 3'd3;
  localparam state_t ST_DRAIN   = 3'd4;

  localparam int RW_BIT      = 7;
  localparam int DATA_BYTES  = 2;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/spi_register_responder_if.sv
// rtl/spi_register_responder_if.sv - SPI pins, host register port and frame status bundle
interface spi_register_responder_if #(parameter int REG_COUNT = 8);
  localparam int ADDR_W = $clog2(REG_COUNT);

  logic              i_SPI_Clk;
  logic              i_SPI_MOSI;
  logic              i_SPI_CS_n;
  logic              o_SPI_MISO;
  logic              host_wr_en;
  logic [ADDR_W-1:0] host_addr;
  logic [15:0]       host_wr_data;
  logic [15:0]       host_rd_data;
  logic              frame_done;
  logic [6:0]        frame_addr;
  logic              frame_is_write;
  logic [3:0]        frame_bytes;
  logic              addr_err;

  modport slave (
    input  i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n, host_wr_en, host_addr, host_wr_data,
    output o_SPI_MISO, host_rd_data, frame_done, frame_addr, frame_is_write, frame_bytes, addr_err
  );

  modport master (
    output i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n, host_wr_en, host_addr, host_wr_data,
    input  o_SPI_MISO, host_rd_data, frame_done, frame_addr, frame_is_write, frame_bytes, addr_err
  );
endinterface

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - synchronises SCLK/MOSI/CS_n into clk and derives edge pulses
module spi_pin_sync
  import spi_responder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic mosi,
  input  logic cs_n,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_s,
  output logic mosi_s
);
  logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, cs_sr;
  logic sclk_d, cs_d;
  logic sclk_s;

  // CS resets as "selected" so a reset released mid-frame waits for a real deselect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sr <= '0;
      mosi_sr <= '0;
      cs_sr   <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
      sclk_d  <= sclk_sr[SYNC_STAGES-1];
      cs_d    <= cs_sr[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign cs_s      = cs_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
endmodule

// File: rtl/spi_register_responder.sv
// rtl/spi_register_responder.sv - SPI mode-0 target exposing a 16-bit register map
// Optional burst auto-increment: SPI_RESPONDER_AUTO_INC_EN
module spi_register_responder
  import spi_responder_pkg::*;
#(
  parameter int         REG_COUNT = 8,
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input logic clk,
  input logic rst,
  spi_register_responder_if.slave bus
);
  localparam int ADDR_W = $clog2(REG_COUNT);
  localparam logic [7:0] REG_COUNT_B = 8'(REG_COUNT);

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_s, mosi_s;

  spi_pin_sync u_sync (
    .clk(clk), .rst(rst),
    .sclk(bus.i_SPI_Clk), .mosi(bus.i_SPI_MOSI), .cs_n(bus.i_SPI_CS_n),
    .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
    .cs_fall(cs_fall), .cs_rise(cs_rise), .cs_s(cs_s), .mosi_s(mosi_s)
  );

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        rx_shreg, tx_shreg, byte0;
  logic [3:0]        frame_bytes_q;
  logic              cur_rw, addr_ok, data_idx;
  logic [6:0]        cur_addr;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       regs [REG_COUNT];
  logic              frame_done_q, frame_is_write_q, addr_err_q;
  logic [6:0]        frame_addr_q;

  logic       byte_done;
  logic [7:0] rx_next, next_byte;
  logic [15:0] rd_word;

  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign rx_next   = {rx_shreg[6:0], mosi_s};
  assign rd_word   = addr_ok ? regs[idx] : 16'h0000;

  // Read words are sampled per load point, so a host write between bytes may tear.
  always_comb begin
    next_byte = IDLE_BYTE;
    if (state == ST_DATA && cur_rw)
      next_byte = data_idx ? rd_word[7:0] : rd_word[15:8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_WAIT_CS;
      bit_cnt          <= '0;
      rx_shreg         <= '0;
      tx_shreg         <= '0;
      byte0            <= '0;
      frame_bytes_q    <= '0;
      cur_rw           <= 1'b0;
      addr_ok          <= 1'b0;
      data_idx         <= 1'b0;
      cur_addr         <= '0;
      idx              <= '0;
      frame_done_q     <= 1'b0;
      frame_is_write_q <= 1'b0;
      frame_addr_q     <= '0;
      addr_err_q       <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      frame_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
      if (bus.host_wr_en) regs[bus.host_addr] <= bus.host_wr_data;

      case (state)
        ST_WAIT_CS: if (cs_s) state <= ST_IDLE;
        ST_IDLE: begin
          if (cs_fall) begin
            state         <= ST_ADDR;
            bit_cnt       <= '0;
            frame_bytes_q <= '0;
            tx_shreg      <= IDLE_BYTE;
          end
        end
        default: begin
          if (cs_rise) begin
            state <= ST_IDLE;
            if (state != ST_ADDR) begin
              frame_done_q     <= 1'b1;
              frame_addr_q     <= cur_addr;
              frame_is_write_q <= ~cur_rw;
            end
          end else begin
            if (sclk_rise) begin
              bit_cnt  <= bit_cnt + 3'd1;
              rx_shreg <= rx_next;
            end
            if (byte_done && frame_bytes_q != 4'hF) frame_bytes_q <= frame_bytes_q + 4'd1;
            if (sclk_fall) tx_shreg <= (bit_cnt == 3'd0) ? next_byte : {tx_shreg[6:0], 1'b0};
            if (byte_done) begin
              case (state)
                ST_ADDR: begin
                  cur_rw     <= rx_next[RW_BIT];
                  cur_addr   <= rx_next[6:0];
                  idx        <= rx_next[ADDR_W-1:0];
                  addr_ok    <= {1'b0, rx_next[6:0]} < REG_COUNT_B;
                  addr_err_q <= !({1'b0, rx_next[6:0]} < REG_COUNT_B);
                  data_idx   <= 1'b0;
                  state      <= ST_DATA;
                end
                ST_DATA: begin
                  if (data_idx != 1'(DATA_BYTES - 1)) begin
                    byte0    <= rx_next;
                    data_idx <= 1'b1;
                  end else begin
                    // Placed after the host write so the SPI commit wins a collision.
                    if (!cur_rw && addr_ok) regs[idx] <= {byte0, rx_next};
                    data_idx <= 1'b0;
`ifdef SPI_RESPONDER_AUTO_INC_EN
                    idx <= idx + 1'b1;
`else
                    state <= ST_DRAIN;
`endif
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.o_SPI_MISO     = ~cs_s & tx_shreg[7];
  assign bus.host_rd_data   = regs[bus.host_addr];
  assign bus.frame_done     = frame_done_q;
  assign bus.frame_addr     = frame_addr_q;
  assign bus.frame_is_write = frame_is_write_q;
  assign bus.frame_bytes    = frame_bytes_q;
  assign bus.addr_err       = addr_err_q;
endmodule

// File: tb/tb_spi_register_responder.sv
// tb/tb_spi_register_responder.sv - scoreboard bench with a frame-level register map model
`timescale 1ns/1ps
module tb_spi_register_responder;
  localparam int REG_COUNT = 8;
  localparam int AW = $clog2(REG_COUNT);
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  typedef logic [7:0] bq_t[$];
  typedef struct {logic [6:0] addr; logic is_write; logic [3:0] nbytes;} frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_register_responder_if #(.REG_COUNT(REG_COUNT)) bus();
  spi_register_responder #(.REG_COUNT(REG_COUNT), .IDLE_BYTE(IDLE_BYTE)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] model [REG_COUNT];
  logic [7:0] exp_miso[$];
  frame_t exp_frame[$];
  int exp_addr_err = 0;
  int seen_addr_err = 0;
  int hp = 5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // MISO monitor: assembles bytes on SCLK rising edges, restarts on CS fall.
  initial begin : miso_mon
    logic [7:0] sh;
    int n;
    sh = '0;
    n = 0;
    forever begin
      @(posedge bus.i_SPI_Clk or negedge bus.i_SPI_CS_n);
      if (bus.i_SPI_Clk && !bus.i_SPI_CS_n) begin
        sh = {sh[6:0], bus.o_SPI_MISO};
        n++;
        if (n == 8) begin
          n = 0;
          if (exp_miso.size() == 0) chk("miso_unexpected_byte", 32'(sh) | 32'h100, 32'(sh));
          else chk("miso_byte", sh, exp_miso.pop_front());
        end
      end else begin
        n = 0;
      end
    end
  end

  initial begin : frame_mon
    forever begin
      @(negedge clk);
      if (bus.addr_err) seen_addr_err++;
      if (bus.frame_done) begin
        if (exp_frame.size() == 0) chk("frame_done_unexpected", 1, 0);
        else begin
          frame_t f;
          f = exp_frame.pop_front();
          chk("frame_addr", bus.frame_addr, f.addr);
          chk("frame_is_write", bus.frame_is_write, f.is_write);
          chk("frame_bytes", bus.frame_bytes, f.nbytes);
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  task automatic model_frame(input bq_t tx);
    int n, r, j;
    logic [6:0] a;
    bit rd, ok, active;
    logic [15:0] w;
    n = tx.size();
    if (n == 0) return;
    a = tx[0][6:0];
    rd = tx[0][7];
    ok = int'(a) < REG_COUNT;
    if (!ok) exp_addr_err++;
    exp_miso.push_back(IDLE_BYTE);
    for (int k = 1; k < n; k++) begin
      j = k - 1;
`ifdef SPI_RESPONDER_AUTO_INC_EN
      r = (int'(a) + j / 2) % REG_COUNT;
      active = 1'b1;
`else
      r = int'(a) % REG_COUNT;
      active = (j < 2);
`endif
      if (rd && active) begin
        w = ok ? model[r] : 16'h0000;
        exp_miso.push_back((j % 2 == 0) ? w[15:8] : w[7:0]);
      end else begin
        exp_miso.push_back(IDLE_BYTE);
      end
      if (!rd && active && ok && (j % 2 == 1)) model[r] = {tx[k-1], tx[k]};
    end
    exp_frame.push_back('{a, !rd, (n > 15) ? 4'hF : 4'(n)});
  endtask

  task automatic xfer(input bq_t tx, input int extra, input int rst_after,
                      input bit coll, input int caddr, input logic [15:0] cdata);
    bus.i_SPI_CS_n = 1'b0;
    repeat (hp) tick();
    for (int b = 0; b < tx.size(); b++) begin
      for (int i = 7; i >= 0; i--) begin
        bus.i_SPI_MOSI = tx[b][i];
        repeat (hp) tick();
        bus.i_SPI_Clk = 1'b1;
        if (coll && b == tx.size() - 1 && i == 0) begin
          bus.host_addr = caddr[AW-1:0];
          bus.host_wr_data = cdata;
          bus.host_wr_en = 1'b1;
          repeat (3) tick();
          bus.host_wr_en = 1'b0;
          repeat (hp - 3) tick();
        end else begin
          repeat (hp) tick();
        end
        bus.i_SPI_Clk = 1'b0;
      end
      if (b == rst_after) begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
      end
    end
    for (int i = 0; i < extra; i++) begin
      bus.i_SPI_MOSI = 1'b1;
      repeat (hp) tick();
      bus.i_SPI_Clk = 1'b1;
      repeat (hp) tick();
      bus.i_SPI_Clk = 1'b0;
    end
    repeat (hp) tick();
    bus.i_SPI_CS_n = 1'b1;
    repeat (2 * hp + 4) tick();
  endtask

  task automatic do_frame(input bq_t tx);
    model_frame(tx);
    xfer(tx, 0, -1, 1'b0, 0, 16'h0);
  endtask

  task automatic host_wr(input int a, input logic [15:0] d);
    bus.host_addr = a[AW-1:0];
    bus.host_wr_data = d;
    bus.host_wr_en = 1'b1;
    tick();
    bus.host_wr_en = 1'b0;
    model[a] = d;
  endtask

  task automatic host_chk(input int a);
    bus.host_addr = a[AW-1:0];
    #1;
    chk($sformatf("reg%0d", a), bus.host_rd_data, model[a]);
  endtask

  initial begin : stim
    bq_t tx;
    int extra, t, na;
    bus.i_SPI_CS_n = 1'b1;
    bus.i_SPI_Clk = 1'b0;
    bus.i_SPI_MOSI = 1'b0;
    bus.host_wr_en = 1'b0;
    bus.host_addr = '0;
    bus.host_wr_data = '0;
    for (int i = 0; i < REG_COUNT; i++) model[i] = 16'h0000;
    repeat (3) tick();
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_frame_addr", bus.frame_addr, 0);
    chk("rst_frame_is_write", bus.frame_is_write, 0);
    chk("rst_frame_bytes", bus.frame_bytes, 0);
    chk("rst_addr_err", bus.addr_err, 0);
    chk("rst_miso", bus.o_SPI_MISO, 0);
    rst = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < REG_COUNT; i++) host_chk(i);

    host_wr(3, 16'hBEEF);
    do_frame('{8'h83, 8'h00, 8'h00});
    do_frame('{8'h05, 8'h12, 8'h34});
    host_chk(5);
    host_wr(6, 16'h5A5A);
    do_frame('{8'h06, 8'hAA});
    host_chk(6);
    tx = {};
    xfer(tx, 4, -1, 1'b0, 0, 16'h0);
    chk("partial_addr_frame_bytes", bus.frame_bytes, 0);

    do_frame('{8'h8A, 8'h00, 8'h00});
    do_frame('{8'h0A, 8'h11, 8'h22});
    for (int i = 0; i < REG_COUNT; i++) host_chk(i);
    chk("addr_err_count", seen_addr_err, exp_addr_err);

    model[2] = 16'hDEAD;
    tx = '{8'h02, 8'hC3, 8'h3C};
    model_frame(tx);
    xfer(tx, 0, -1, 1'b1, 2, 16'hDEAD);
    host_chk(2);
    model[1] = 16'hB0B0;
    tx = '{8'h02, 8'h44, 8'h55};
    model_frame(tx);
    xfer(tx, 0, -1, 1'b1, 1, 16'hB0B0);
    host_chk(1);
    host_chk(2);

    tx = '{8'h81};
    for (int i = 0; i < 17; i++) tx.push_back(8'h00);
    do_frame(tx);

    // Reset mid-frame: nothing after the reset is decoded until CS deasserts.
    exp_miso.push_back(IDLE_BYTE);
    exp_miso.push_back(8'h00);
    exp_miso.push_back(8'h00);
    for (int i = 0; i < REG_COUNT; i++) model[i] = 16'h0000;
    xfer('{8'h04, 8'h55, 8'h66}, 0, 0, 1'b0, 0, 16'h0);
    chk("post_rst_frame_bytes", bus.frame_bytes, 0);
    chk("post_rst_frame_addr", bus.frame_addr, 0);
    host_chk(3);
    host_chk(4);
    do_frame('{8'h04, 8'h77, 8'h88});
    host_chk(4);

`ifdef SPI_RESPONDER_AUTO_INC_EN
    host_wr(0, 16'h1111);
    host_wr(1, 16'h2222);
    do_frame('{8'h80, 8'h00, 8'h00, 8'h00, 8'h00});
    host_wr(7, 16'h7777);
    do_frame('{8'h87, 8'h00, 8'h00, 8'h00, 8'h00});
    do_frame('{8'h06, 8'hA1, 8'hA2, 8'hB1, 8'hB2});
    host_chk(6);
    host_chk(7);
`endif

    for (int f = 0; f < 24; f++) begin
      hp = $urandom_range(5, 8);
      if ($urandom_range(0, 3) == 0) host_wr($urandom_range(0, REG_COUNT - 1), 16'($urandom));
      tx = {};
      na = $urandom_range(0, 5);
      if (na > 0) begin
        tx.push_back({1'($urandom), 7'($urandom_range(0, 9))});
        for (int i = 1; i < na; i++) tx.push_back(8'($urandom));
      end
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      model_frame(tx);
      xfer(tx, extra, -1, 1'b0, 0, 16'h0);
      host_chk($urandom_range(0, REG_COUNT - 1));
    end
    hp = 5;

    t = 0;
    while ((exp_miso.size() != 0 || exp_frame.size() != 0) && t < 200) begin
      tick();
      t++;
    end
    chk("miso_queue_drained", exp_miso.size(), 0);
    chk("frame_queue_drained", exp_frame.size(), 0);
    chk("addr_err_total", seen_addr_err, exp_addr_err);
    for (int i = 0; i < REG_COUNT; i++) host_chk(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_register_responder.md
Name: spi_register_responder

Overview:
- SPI target (slave) that emulates a sensor register map for the command-to-SPI path.
- Answers SPI frames of the form: one address byte on MOSI, then two data bytes, MSB first, returned on MISO.
- Oversamples SPI pins in the system clock domain. Used as a bench/loopback sensor model and as an on-chip register target.
- A host-side port preloads and inspects the 16-bit registers.

Parameters:
- REG_COUNT, 8, number of 16-bit registers; must be a power of 2, range 2..128.
- IDLE_BYTE, 8'h00, byte driven on MISO during the address byte and in DRAIN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_SPI_Clk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
- i_SPI_MOSI  in  1  master data
- i_SPI_CS_n  in  1  active-low chip select
- o_SPI_MISO  out  1  target data
- host_wr_en  in  1  host register write strobe
- host_addr  in  $clog2(REG_COUNT)  host read/write index
- host_wr_data  in  16  host write data
- host_rd_data  out  16  combinational read of reg[host_addr]
- frame_done  out  1  one-cycle pulse when a frame ends
- frame_addr  out  7  address of the last frame
- frame_is_write  out  1  R/W flag of the last frame
- frame_bytes  out  4  completed bytes in the last frame, saturating at 15
- addr_err  out  1  one-cycle pulse for an out-of-range address

Behaviour:
- Reset: all registers 0x0000; o_SPI_MISO=0; frame_done=0; frame_addr=0; frame_is_write=0; frame_bytes=0; addr_err=0; state WAIT_CS.
- Synchronisation: i_SPI_Clk, i_SPI_MOSI and i_SPI_CS_n each pass through a 2-FF synchroniser. Edges are detected from the synchronised values.
- Timing: pin-to-action latency is 3 clk. The master's SCLK half period must be at least 5 clk.
- Address byte format: bit7=1 means read, 0 means write; bits[6:0] are the register index.
- Bit counter: 3-bit, counts SCLK rising edges while CS is low, wraps 7→0. Rising edges shift MOSI into rx_shreg (LSB in).
- MISO shift register: o_SPI_MISO=tx_shreg[7] while CS is low, 0 while CS is high.
  - On a falling edge with bit_cnt==0 (a byte has just completed), load the next response byte.
  - On any other falling edge, shift left.
  - On CS falling, tx_shreg=IDLE_BYTE.
- States:
  - WAIT_CS: entered after reset. Moves to IDLE on synchronised CS high. This prevents a mid-frame reset release from decoding garbage.
  - IDLE: CS falling → ADDR; clear bit_cnt and frame_bytes.
  - ADDR: on the 8th rising edge, latch R/W and address, then go to DATA.
    - Address ≥ REG_COUNT: pulse addr_err; reads return 0x0000; writes are ignored.
  - DATA, read: at the load points, byte0=reg[a][15:8] and byte1=reg[a][7:0]. After byte1 completes, go to DRAIN.
  - DATA, write: the first byte is held; on completion of the second byte, reg[a]={byte0,byte1} is committed in that cycle. Then go to DRAIN.
  - DRAIN: MISO loads IDLE_BYTE; MOSI is ignored; frame_bytes keeps counting.
- CS rising (synchronised), from any state except WAIT_CS/IDLE:
  - Return to IDLE.
  - If the address byte completed, pulse frame_done one cycle later and update frame_addr and frame_is_write. frame_bytes holds the count.
  - A partial byte is discarded. A write with fewer than two data bytes is not committed.
- CS rising inside ADDR: no frame_done, no pulse outputs.
- Simultaneous SPI commit and host_wr_en to the same register: SPI write wins. Different registers: both commit.
- Read data is sampled at each byte load point. A host write between byte0 and byte1 can tear the word; this is accepted and documented.
- rst asserted mid-frame: immediate return to reset values, then WAIT_CS.

Optional Feature:
- Macro: SPI_RESPONDER_AUTO_INC_EN
- Defined:
  - After each 2 data bytes, the index increments, wrapping modulo REG_COUNT, and DATA continues (burst reads and writes).
  - DRAIN is unused.
  - Each write commits per completed byte pair.
- Undefined: behaviour exactly as above, with a single register per frame.

Decomposition:
- Package spi_responder_pkg: state enum (WAIT_CS, IDLE, ADDR, DATA, DRAIN), RW_BIT=7, DATA_BYTES=2, SYNC_STAGES=2.
- One sub-module: spi_pin_sync.
  - 2-FF synchronisers for the three pins.
  - Outputs sclk_rise, sclk_fall, cs_fall, cs_rise pulses and mosi_s.

Test Plan:
- Read: host writes reg3=0xBEEF; master sends 0x83 plus 2 dummy bytes, half period 5 clk → MISO 0x00,0xBE,0xEF; frame_done with frame_addr=3, frame_is_write=0, frame_bytes=3.
- Write: master sends 0x05,0x12,0x34 → host_rd_data at addr 5 = 0x1234; frame_is_write=1.
- Aborted write: 0x06,0xAA, then CS high → reg6 unchanged; frame_done=1 with frame_bytes=2. CS high after 4 bits → no frame_done.
- Out of range: REG_COUNT=8, address 0x8A → addr_err pulse; MISO 0x00,0x00,0x00. Write 0x0A,0x11,0x22 changes no register.
- Collision and reset: SPI write to reg2 coincides with host_wr_en to reg2 → SPI value kept. rst pulsed mid-frame with CS low → no response until CS high, then the next frame works.
- Auto-increment (macro defined): reg0=0x1111, reg1=0x2222; read 0x80 with 4 data bytes → 0x11,0x11,0x22,0x22. Read from reg7 wraps to reg0.
